scroll_sequencer: RTL and testbench
===================================

Name: scroll_sequencer

Overview:
- Parametrised successor to the single-mode scroll column counter.
- Generates the horizontal scroll offset that the frame/row fetch logic of the 32x16 LED matrix controller adds to the message column address.
- Adds runtime length, frame-rate prescaling, direction, and wrap/one-shot/ping-pong modes.
- Advances only on frame boundaries (frame_tick from the refresh controller).

Parameters:
- POS_W, 10, width of scroll position and length.
- SPD_W, 8, width of speed (prescale) field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per completed display frame
- start  in  1  pulse; latch config and begin scrolling
- stop  in  1  pulse; abort to IDLE
- mode  in  2  0=WRAP, 1=ONESHOT, 2=PINGPONG, 3=treated as WRAP
- dir  in  1  0=forward (increasing), 1=reverse
- length  in  POS_W  number of scroll positions; 0 treated as 1
- speed  in  SPD_W  frame_ticks per step minus 1
- scroll_pos  out  POS_W  current offset, registered
- busy  out  1  high in RUN
- step_pulse  out  1  one cycle, coincident with each scroll_pos update
- wrap_pulse  out  1  one cycle on wrap or ping-pong turnaround
- done  out  1  level, high in DONE state

Behaviour:
- Reset: state IDLE; scroll_pos=0, busy=0, step_pulse=0, wrap_pulse=0, done=0; prescaler=0; latched config cleared.
- Priority: rst > stop > start > step.
- FSM:
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE. ONESHOT endpoint reached -> DONE.
  - DONE: start -> RUN; stop -> IDLE.
- start (any state): latch mode, dir, length (len_l = max(length,1)) and speed into registers; clear prescaler. Next cycle: busy=1, done=0, scroll_pos = 0 if dir=0, else len_l-1. Start during RUN restarts.
- Inputs mode/dir/length/speed are ignored outside the start cycle.
- stop: next cycle IDLE, busy=0, done=0. scroll_pos holds its last value.
- Prescaler (RUN only): on frame_tick, if presc==speed_l then step and presc<=0, else presc++. One step per speed_l+1 frame_ticks. frame_tick outside RUN is ignored.
- Step, forward:
  - pos<len_l-1: pos+1.
  - At len_l-1: WRAP -> 0 with wrap_pulse. ONESHOT -> no move, enter DONE. PINGPONG -> flip internal dir, pos-1, wrap_pulse.
- Step, reverse: mirror image, with endpoint 0. WRAP goes to len_l-1.
- len_l=1: pos stays 0. WRAP/PINGPONG still pulse wrap_pulse and step_pulse every step; ONESHOT enters DONE on its first step.
- step_pulse fires only when scroll_pos actually updates or wraps. No step_pulse on the ONESHOT terminal step.
- Arithmetic is modulo-free; wrap is explicit compare. No overflow is possible given len_l <= 2^POS_W-1.

Optional Feature:
- SCROLL_PAUSE_EN defined: adds input port pause (1 bit). While pause=1 in RUN:
  - frame_tick is ignored; prescaler and scroll_pos are frozen.
  - busy stays 1.
  - stop and start still act.
- Not defined: no pause port; behaviour as above.

Decomposition:
- Package scroll_pkg holds:
  - typedef enum scroll_mode_e {SCR_WRAP, SCR_ONESHOT, SCR_PINGPONG, SCR_RSVD};
  - typedef enum scroll_state_e {S_IDLE, S_RUN, S_DONE};
  - default POS_W/SPD_W localparams shared with the frame controller.
- One sub-module is natural: scroll_prescaler (frame_tick divider with clear and enable, outputs step_en).

Test Plan:
- Reset during RUN at pos=37: next cycle scroll_pos=0, busy=0, done=0, state IDLE.
- WRAP, dir=0, length=5, speed=0, continuous frame_tick: pos 0,1,2,3,4,0; wrap_pulse once, on the 4->0 step.
- ONESHOT, dir=1, length=4, speed=2: pos 3 at start. Steps every 3rd frame_tick: 2,1,0. Next step -> done=1, busy=0, pos=0, no step_pulse.
- PINGPONG, dir=0, length=3, speed=0: sequence 0,1,2,1,0,1; wrap_pulse at 2->1 and 0->1.
- length=0, WRAP: pos stays 0 and wrap_pulse every step. Then start+stop in the same cycle -> IDLE, busy=0.
- SCROLL_PAUSE_EN: pause for 10 frame_ticks mid-run at pos=7 -> pos stays 7 and step timing resumes without lost prescaler count. Build without the macro must compile with no pause port.

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared scroll types and default widths for the LED matrix scroll path.
package scroll_pkg;

  localparam int unsigned SCROLL_POS_W = 10;
  localparam int unsigned SCROLL_SPD_W = 8;

  typedef enum logic [1:0] {
    SCR_WRAP     = 2'd0,
    SCR_ONESHOT  = 2'd1,
    SCR_PINGPONG = 2'd2,
    SCR_RSVD     = 2'd3
  } scroll_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } scroll_state_e;

endpackage

// File: rtl/scroll_prescaler.sv
// Frame-tick divider: step_en fires on every (speed+1)-th enabled tick.
module scroll_prescaler #(
  parameter int unsigned SPD_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             tick,
  input  logic [SPD_W-1:0] speed,
  output logic             step_en
);

  logic [SPD_W-1:0] presc_q;

  assign step_en = enable & tick & (presc_q == speed);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      presc_q <= '0;
    end else if (enable && tick) begin
      presc_q <= step_en ? '0 : presc_q + 1'b1;
    end
  end

endmodule

// File: rtl/scroll_sequencer.sv
// Horizontal scroll offset generator with wrap/one-shot/ping-pong modes.
// Optional `define SCROLL_PAUSE_EN adds a pause input that freezes RUN.
module scroll_sequencer
  import scroll_pkg::*;
#(
  parameter int unsigned POS_W = SCROLL_POS_W,
  parameter int unsigned SPD_W = SCROLL_SPD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             start,
  input  logic             stop,
`ifdef SCROLL_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [POS_W-1:0] length,
  input  logic [SPD_W-1:0] speed,
  output logic [POS_W-1:0] scroll_pos,
  output logic             busy,
  output logic             step_pulse,
  output logic             wrap_pulse,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_RUN  = S_RUN;
  localparam logic [1:0] ST_DONE = S_DONE;

  logic [1:0]       state_q, state_d;
  scroll_mode_e     mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [POS_W-1:0] len_q, len_d;
  logic [SPD_W-1:0] speed_q, speed_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [POS_W-1:0] last;
  logic             at_end;
  logic             run_en;
  logic             step_en;

`ifdef SCROLL_PAUSE_EN
  assign run_en = (state_q == ST_RUN) & ~pause;
`else
  assign run_en = (state_q == ST_RUN);
`endif

  scroll_prescaler #(
    .SPD_W (SPD_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clear   (start | stop),
    .enable  (run_en),
    .tick    (frame_tick),
    .speed   (speed_q),
    .step_en (step_en)
  );

  assign last   = len_q - 1'b1;
  assign at_end = dir_q ? (pos_q == '0) : (pos_q == last);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    len_d   = len_q;
    speed_d = speed_q;
    pos_d   = pos_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_RUN;
      mode_d  = (mode == SCR_RSVD) ? SCR_WRAP : scroll_mode_e'(mode);
      dir_d   = dir;
      len_d   = (length == '0) ? POS_W'(1) : length;
      speed_d = speed;
      pos_d   = dir ? len_d - 1'b1 : '0;
    end else if (step_en) begin
      if (!at_end) begin
        pos_d  = dir_q ? pos_q - 1'b1 : pos_q + 1'b1;
        step_d = 1'b1;
      end else begin
        case (mode_q)
          SCR_ONESHOT: state_d = ST_DONE;
          SCR_PINGPONG: begin
            dir_d  = ~dir_q;
            step_d = 1'b1;
            wrap_d = 1'b1;
            // A single-position run has nowhere to bounce to.
            if (len_q != POS_W'(1)) pos_d = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
          end
          default: begin
            pos_d  = dir_q ? last : '0;
            step_d = 1'b1;
            wrap_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= SCR_WRAP;
      dir_q   <= 1'b0;
      len_q   <= '0;
      speed_q <= '0;
      pos_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      speed_q <= speed_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign scroll_pos = pos_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign step_pulse = step_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Randomized bench for scroll_sequencer against a sequence-table reference model.
module tb_scroll_sequencer;
  import scroll_pkg::*;

  localparam int unsigned POS_W = 10;
  localparam int unsigned SPD_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             frame_tick = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             pause = 1'b0;
  logic [1:0]       mode = '0;
  logic             dir = 1'b0;
  logic [POS_W-1:0] length = '0;
  logic [SPD_W-1:0] speed = '0;
  logic [POS_W-1:0] scroll_pos;
  logic             busy, step_pulse, wrap_pulse, done;

  scroll_sequencer #(
    .POS_W (POS_W),
    .SPD_W (SPD_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .stop       (stop),
`ifdef SCROLL_PAUSE_EN
    .pause      (pause),
`endif
    .mode       (mode),
    .dir        (dir),
    .length     (length),
    .speed      (speed),
    .scroll_pos (scroll_pos),
    .busy       (busy),
    .step_pulse (step_pulse),
    .wrap_pulse (wrap_pulse),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each run is a precomputed table of positions visited.
  int m_state = 0;  // 0 idle, 1 run, 2 done
  int m_pos = 0, m_mode = 0, m_len = 1, m_speed = 0, m_cnt = 0, m_k = 0;
  bit m_step = 0, m_wrap = 0;
  int seq[$];

  function automatic void m_start(input int md, input int d, input int len, input int spd);
    int n;
    n = (len == 0) ? 1 : len;
    m_mode = (md == 3) ? 0 : md;
    m_len = n;
    m_speed = spd;
    seq.delete();
    for (int i = 0; i < n; i++) seq.push_back(d ? n - 1 - i : i);
    if (m_mode == 2)
      for (int i = 1; i <= n - 2; i++) seq.push_back(d ? i : n - 1 - i);
    m_k = 0;
    m_cnt = 0;
    m_pos = seq[0];
    m_state = 1;
  endfunction

  function automatic void m_do_step();
    int idx;
    idx = m_k % seq.size();
    if (m_mode == 1 && idx == m_len - 1) begin
      m_state = 2;
    end else begin
      m_step = 1;
      m_wrap = (idx == m_len - 1) || (m_mode == 2 && idx == 0 && m_k > 0);
      m_k++;
      m_pos = seq[m_k % seq.size()];
    end
  endfunction

  task automatic cyc(input bit r, input bit ft, input bit st, input bit sp, input int md,
                     input bit d, input int len, input int spd, input bit pz);
    int mdv, lenv, spdv;
    bit paused;
    mdv = md; lenv = len; spdv = spd;
    @(negedge clk);
    rst = r; frame_tick = ft; start = st; stop = sp; pause = pz;
    mode = mdv[1:0]; dir = d; length = lenv[POS_W-1:0]; speed = spdv[SPD_W-1:0];
`ifdef SCROLL_PAUSE_EN
    paused = pz;
`else
    paused = 0;
`endif
    m_step = 0;
    m_wrap = 0;
    if (r) begin
      m_state = 0; m_pos = 0; m_cnt = 0;
    end else if (sp) begin
      m_state = 0; m_cnt = 0;
    end else if (st) begin
      m_start(mdv, d, lenv, spdv);
    end else if (m_state == 1 && ft && !paused) begin
      if (m_cnt == m_speed) begin
        m_cnt = 0;
        m_do_step();
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    check("pos", scroll_pos, m_pos);
    check("busy", busy, m_state == 1);
    check("done", done, m_state == 2);
    check("step_pulse", step_pulse, m_step);
    check("wrap_pulse", wrap_pulse, m_wrap);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int wraps;

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while running at position 37.
    cyc(0, 0, 1, 0, 0, 0, 100, 0, 0);
    for (int i = 0; i < 200 && scroll_pos != 37; i++) tick(1);
    check("reach_37", scroll_pos, 37);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_pos", scroll_pos, 0);
    check("rst_busy", busy, 0);

    // WRAP forward, length 5.
    cyc(0, 0, 1, 0, 0, 0, 5, 0, 0);
    wraps = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (wrap_pulse) wraps++;
    end
    check("wrap5_count", wraps, 1);
    check("wrap5_pos", scroll_pos, 0);

    // ONESHOT reverse, length 4, speed 2.
    cyc(0, 0, 1, 0, 1, 1, 4, 2, 0);
    check("oneshot_init", scroll_pos, 3);
    tick(12);
    check("oneshot_done", done, 1);
    check("oneshot_pos", scroll_pos, 0);
    tick(4);

    // PINGPONG forward, length 3.
    cyc(0, 0, 1, 0, 2, 0, 3, 0, 0);
    tick(5);
    check("pp_pos", scroll_pos, 1);

    // Length 0 treated as 1, then start and stop together.
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick(4);
    cyc(0, 1, 1, 1, 0, 0, 6, 0, 0);
    check("startstop_busy", busy, 0);
    tick(3);

`ifdef SCROLL_PAUSE_EN
    // Pause mid-run at position 7.
    cyc(0, 0, 1, 0, 0, 0, 20, 1, 0);
    for (int i = 0; i < 100 && scroll_pos != 7; i++) tick(1);
    check("pause_reach_7", scroll_pos, 7);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
    check("pause_hold", scroll_pos, 7);
    tick(6);
`endif

    for (int i = 0; i < 3000; i++) begin
      int len, spd;
      len = ($urandom % 8 == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 9);
      spd = ($urandom % 6 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
      cyc($urandom % 400 == 0, $urandom % 3 != 0, $urandom % 40 == 0, $urandom % 60 == 0,
          $urandom % 4, $urandom % 2, len, spd, $urandom % 5 == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
